// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetches words from instruction memory into a 2-entry buffer feeding decode, with redirect, halt and fault handling
module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int RESET_PC = 0,
  parameter int PC_LIMIT = 1024,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD = '1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  F_PC,
  input  logic [INSTR_WIDTH-1:0] Instr,
  output logic                   D_valid,
  input  logic                   D_ready,
  output logic [INSTR_WIDTH-1:0] D_Instr,
  output logic [ADDR_WIDTH-1:0]  D_PC,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_PC,
  output logic                   halt,
  output logic                   fault
);
  typedef enum logic [1:0] {FETCH, HALTED, FAULT} state_t;
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(PC_LIMIT);
  state_t state, state_n;
  logic [INSTR_WIDTH-1:0] e1_instr;
  logic [ADDR_WIDTH-1:0] e1_pc;
  logic e1_valid, pop, space, in_range, push, shift, is_halt;
  assign pop = D_valid && D_ready;
  assign space = !e1_valid || pop;
  assign in_range = F_PC < LIMIT;
  assign is_halt = Instr == HALT_WORD;
  assign push = state == FETCH && !redirect_valid && space && in_range;
  assign shift = pop || !D_valid;
  assign fault = state == FAULT;
  always_ff @(posedge clk)
    state <= reset ? FETCH : state_n;
  always_comb begin
    state_n = state;
    state_n = redirect_valid ? FETCH :
              (state != FETCH || !space) ? state :
              !in_range ? FAULT :
              is_halt ? HALTED : FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      F_PC <= ADDR_WIDTH'(RESET_PC);
      D_valid <= 1'b0;
      D_Instr <= '0;
      D_PC <= '0;
      e1_valid <= 1'b0;
      e1_instr <= '0;
      e1_pc <= '0;
      halt <= 1'b0;
    end else if (redirect_valid) begin
      F_PC <= redirect_PC;
      D_valid <= 1'b0;
      e1_valid <= 1'b0;
      halt <= 1'b0;
    end else begin
      if (push && !is_halt)
        F_PC <= F_PC + ADDR_WIDTH'(1);
      if (pop && D_Instr == HALT_WORD)
        halt <= 1'b1;
      if (shift) begin
        D_valid <= e1_valid || push;
        e1_valid <= e1_valid && push;
        if (e1_valid) begin
          D_Instr <= e1_instr;
          D_PC <= e1_pc;
        end else if (push) begin
          D_Instr <= Instr;
          D_PC <= F_PC;
        end
        if (e1_valid && push) begin
          e1_instr <= Instr;
          e1_pc <= F_PC;
        end
      end else if (push) begin
        e1_valid <= 1'b1;
        e1_instr <= Instr;
        e1_pc <= F_PC;
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
  logic clk = 1'b0;
  logic reset, D_ready, redirect_valid, D_valid, halt, fault;
  logic [31:0] redirect_PC, F_PC, Instr, D_Instr, D_PC;
  logic f_reset, f_ready, f_dvalid, f_halt, f_fault;
  logic f_rv = 1'b0;
  logic [31:0] f_rpc = 32'h0;
  logic [31:0] f_pc, f_instr, f_dinstr, f_dpc;
  logic [31:0] mem [256];
  logic [63:0] q [$];
  logic [63:0] e_a, e_b;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign Instr = F_PC < 256 ? mem[F_PC[7:0]] : 32'h0;
  assign f_instr = f_pc < 256 ? mem[f_pc[7:0]] : 32'h0;
  instruction_fetch_unit u_dut (
    .clk(clk), .reset(reset), .F_PC(F_PC), .Instr(Instr),
    .D_valid(D_valid), .D_ready(D_ready), .D_Instr(D_Instr), .D_PC(D_PC),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
    .halt(halt), .fault(fault)
  );
  instruction_fetch_unit #(.PC_LIMIT(4), .RESET_PC(2)) u_flt (
    .clk(clk), .reset(f_reset), .F_PC(f_pc), .Instr(f_instr),
    .D_valid(f_dvalid), .D_ready(f_ready), .D_Instr(f_dinstr), .D_PC(f_dpc),
    .redirect_valid(f_rv), .redirect_PC(f_rpc),
    .halt(f_halt), .fault(f_fault)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic exp_pc(input logic [31:0] pc);
    q.push_back({pc, mem[pc[7:0]]});
  endtask
  task automatic drain;
    for (int i = 0; i < 50 && q.size() > 0; i++) step;
    chk("drain", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk)
    if (!reset && D_valid && D_ready && q.size() > 0) begin
      e_a = q.pop_front();
      chk("pc", 64'(D_PC), 64'(e_a[63:32]));
      chk("instr", 64'(D_Instr), 64'(e_a[31:0]));
    end
  always @(negedge clk)
    if (!f_reset && f_dvalid && f_ready && q.size() > 0) begin
      e_b = q.pop_front();
      chk("flt_pc", 64'(f_dpc), 64'(e_b[63:32]));
      chk("flt_instr", 64'(f_dinstr), 64'(e_b[31:0]));
    end
  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    reset = 1'b1; D_ready = 1'b0; redirect_valid = 1'b0; redirect_PC = 32'h0;
    f_reset = 1'b1; f_ready = 1'b0;
    step; step;
    chk("rst_fpc", 64'(F_PC), 64'd0);
    chk("rst_dvalid", 64'(D_valid), 64'd0);
    chk("rst_dinstr", 64'(D_Instr), 64'd0);
    chk("rst_dpc", 64'(D_PC), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("flt_rst_fpc", 64'(f_pc), 64'd2);
    chk("flt_rst_fault", 64'(f_fault), 64'd0);
    for (int i = 0; i < 8; i++) exp_pc(32'(i));
    reset = 1'b0; D_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step;
      chk("run_valid", 64'(D_valid), 64'd1);
      chk("run_dpc", 64'(D_PC), 64'(i));
    end
    drain;
    reset = 1'b1; D_ready = 1'b0;
    step; step;
    reset = 1'b0;
    step;
    chk("bp_valid", 64'(D_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("bp_instr", 64'(D_Instr), 64'h100);
      chk("bp_dpc", 64'(D_PC), 64'd0);
    end
    chk("bp_fpc", 64'(F_PC), 64'd2);
    for (int i = 0; i < 4; i++) exp_pc(32'(i));
    D_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("bp_flow_valid", 64'(D_valid), 64'd1);
      chk("bp_flow_dpc", 64'(D_PC), 64'(i + 1));
    end
    drain;
    D_ready = 1'b0;
    chk("mid_pre_valid", 64'(D_valid), 64'd1);
    reset = 1'b1;
    step;
    chk("mid_dvalid", 64'(D_valid), 64'd0);
    chk("mid_fpc", 64'(F_PC), 64'd0);
    step;
    reset = 1'b0;
    step; step;
    chk("rd_pre_fpc", 64'(F_PC), 64'd2);
    redirect_valid = 1'b1; redirect_PC = 32'h20;
    step;
    chk("rd_dvalid", 64'(D_valid), 64'd0);
    chk("rd_fpc", 64'(F_PC), 64'h20);
    redirect_valid = 1'b0;
    step;
    chk("rd_valid2", 64'(D_valid), 64'd1);
    chk("rd_dpc", 64'(D_PC), 64'h20);
    chk("rd_instr", 64'(D_Instr), 64'h120);
    for (int i = 0; i < 3; i++) exp_pc(32'h20 + 32'(i));
    D_ready = 1'b1;
    drain;
    D_ready = 1'b0; reset = 1'b1;
    step;
    mem[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) exp_pc(32'(i));
    reset = 1'b0; D_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("hlt_dpc", 64'(D_PC), 64'(i));
      chk("hlt_early", 64'(halt), 64'd0);
    end
    chk("hlt_fpc", 64'(F_PC), 64'd3);
    step;
    chk("hlt_set", 64'(halt), 64'd1);
    chk("hlt_dvalid", 64'(D_valid), 64'd0);
    chk("hlt_fpc2", 64'(F_PC), 64'd3);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("hlt_idle", 64'(D_valid), 64'd0);
      chk("hlt_sticky", 64'(halt), 64'd1);
    end
    drain;
    for (int i = 0; i < 4; i++) exp_pc(32'(i));
    redirect_valid = 1'b1; redirect_PC = 32'h0;
    step;
    redirect_valid = 1'b0;
    chk("hlt_clr", 64'(halt), 64'd0);
    chk("hlt_rd_fpc", 64'(F_PC), 64'd0);
    drain;
    mem[3] = 32'h103;
    reset = 1'b1; D_ready = 1'b0;
    step;
    exp_pc(32'd2); exp_pc(32'd3);
    f_reset = 1'b0; f_ready = 1'b1;
    step;
    chk("flt_dpc0", 64'(f_dpc), 64'd2);
    step;
    chk("flt_dpc1", 64'(f_dpc), 64'd3);
    chk("flt_early", 64'(f_fault), 64'd0);
    chk("flt_fpc", 64'(f_pc), 64'd4);
    step;
    chk("flt_set", 64'(f_fault), 64'd1);
    chk("flt_dvalid", 64'(f_dvalid), 64'd0);
    chk("flt_fpc2", 64'(f_pc), 64'd4);
    step; step;
    chk("flt_hold_fpc", 64'(f_pc), 64'd4);
    chk("flt_sticky", 64'(f_fault), 64'd1);
    chk("flt_idle", 64'(f_dvalid), 64'd0);
    chk("flt_halt", 64'(f_halt), 64'd0);
    drain;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction memory port. It drives the word-addressed fetch PC (F_PC) and captures the combinational Instr word returned in the same cycle. Fetched {PC, instruction} pairs go into a 2-entry buffer and are handed to decode over a valid/ready handshake. The block also handles branch redirects, halt detection and out-of-range PC faults.

Parameters:
ADDR_WIDTH, 32, width of F_PC, D_PC and redirect_PC.
INSTR_WIDTH, 32, width of Instr and D_Instr.
RESET_PC, 0, word address loaded into F_PC on reset.
PC_LIMIT, 1024, number of valid memory words; a fetch is legal only when F_PC < PC_LIMIT.
HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetching.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
F_PC  output  ADDR_WIDTH  word address presented to instruction memory.
Instr  input  INSTR_WIDTH  memory data for F_PC, valid combinationally in the same cycle.
D_valid  output  1  buffer head holds a valid instruction.
D_ready  input  1  decode accepts the head this cycle.
D_Instr  output  INSTR_WIDTH  instruction at the buffer head.
D_PC  output  ADDR_WIDTH  word address of D_Instr.
redirect_valid  input  1  branch/jump redirect request.
redirect_PC  input  ADDR_WIDTH  redirect target word address.
halt  output  1  sticky; the HALT_WORD has been consumed by decode.
fault  output  1  sticky; a fetch was attempted at F_PC >= PC_LIMIT.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. When reset=1 at a rising edge, all state takes its reset value, overriding every other input.
- Reset values:
  - F_PC=RESET_PC.
  - D_valid=0, D_Instr=0, D_PC=0.
  - halt=0, fault=0.
  - Buffer count=0, state=FETCH.
- Signal definitions:
  - pop = D_valid && D_ready.
  - space = (count<2) || pop.
- States:
  - FETCH, HALTED, FAULT.
- Priority, highest first: reset > redirect_valid > fetch/pop.
- FETCH, no redirect:
  - If space and F_PC<PC_LIMIT: push {F_PC, Instr} at the buffer tail and set F_PC<=F_PC+1 (ADDR_WIDTH wrap, no carry out).
  - If the pushed Instr==HALT_WORD: state<=HALTED and F_PC is held, not incremented.
  - If space and F_PC>=PC_LIMIT: no push, state<=FAULT, fault<=1, F_PC held.
  - If no space: no push, F_PC held.
- HALTED: no pushes, F_PC held, buffer keeps draining normally.
- FAULT: no pushes, F_PC held, buffer keeps draining normally.
- halt is set to 1 on the cycle after the HALT_WORD entry is popped. It stays 1 until reset or redirect.
- Redirect cycle:
  - Buffer flushed (count<=0, D_valid<=0).
  - F_PC<=redirect_PC, state<=FETCH, halt<=0, fault<=0.
  - No push that cycle.
  - A pop asserted in the same cycle counts as completed; decode owns the squash decision.
- Simultaneous push and pop with count=2: allowed. The head shifts out, the new entry enters the tail, and count stays 2.
- Buffer ordering: strict FIFO. D_Instr, D_PC and D_valid are registered outputs taken from the head entry. D_Instr and D_PC are held stable while D_valid=1 and D_ready=0.
- Latency:
  - Instruction at address A is on D_Instr one cycle after F_PC==A when the buffer has space.
  - After reset deasserts, the first cycle presents F_PC=RESET_PC and D_valid=1 the next cycle.
  - With D_ready held high, throughput is 1 instruction per cycle.
- Backpressure: with D_ready low, at most 2 instructions are buffered. F_PC then stalls at the next unfetched address; no instruction is lost or duplicated.
- Reset mid-operation: buffer discarded, D_valid=0, F_PC=RESET_PC on the following cycle.

Test Plan:
- Free-run: memory words 0..7 = 0x100+i, D_ready=1 -> D_PC=0,1,2,… on consecutive cycles with D_Instr=0x100+D_PC, D_valid continuously 1 after the first cycle.
- Backpressure: D_ready=0 for 5 cycles after the first fetch -> count=2, F_PC frozen at 2, D_Instr=0x100 stable. Then D_ready=1 -> sequence 0,1,2,3 with no gap or duplicate.
- Redirect: redirect_valid=1 with redirect_PC=0x20 while 2 entries are buffered -> next cycle D_valid=0 and F_PC=0x20; following cycle D_PC=0x20.
- Halt: word 3 = 0xFFFFFFFF -> F_PC holds at 3, entries 0..3 delivered, halt=1 one cycle after PC 3 is popped, no further D_valid. A subsequent redirect to 0 clears halt and resumes fetching.
- Fault: PC_LIMIT=4, RESET_PC=2 -> PCs 2,3 delivered, fault=1 and state FAULT when F_PC=4, F_PC stays 4, D_valid falls after draining.
- Reset mid-stream: reset=1 for 1 cycle with 2 entries buffered -> D_valid=0 and F_PC=RESET_PC next cycle; fetch restarts from RESET_PC.
